// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronizes and debounces the optical sensor, measures pulse width,
// classifies it as a 5/10-unit coin or invalid. Optional debouncer: COIN_ACCEPTOR_DEBOUNCE_EN.
module coin_acceptor #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int CNT_W       = 8,
  parameter int W5_MIN      = 8,
  parameter int W5_MAX      = 15,
  parameter int W10_MIN     = 24,
  parameter int W10_MAX     = 39,
  parameter int TIMEOUT     = 255,
  parameter int GAP_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor,
  input  logic       accept_en,
  output logic [1:0] coin,
  output logic       coin_reject,
  output logic       jam,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    MEASURE,
    CLASSIFY,
    EMIT,
    REJECT,
    JAM,
    GAP
  } state_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] W5_MIN_C  = CNT_W'(W5_MIN);
  localparam logic [CNT_W-1:0] W5_MAX_C  = CNT_W'(W5_MAX);
  localparam logic [CNT_W-1:0] W10_MIN_C = CNT_W'(W10_MIN);
  localparam logic [CNT_W-1:0] W10_MAX_C = CNT_W'(W10_MAX);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic                   s_db;
  logic                   s_prev;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic                   acc_l;
  logic                   in_w5;
  logic                   in_w10;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= sensor;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];

`ifdef COIN_ACCEPTOR_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [DEB_W-1:0] deb_cnt;

  // Any sample matching the current level restarts the run of differing samples.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s_db    <= 1'b1;
      deb_cnt <= '0;
    end else if (s_sync == s_db) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      s_db    <= s_sync;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end
`else
  // DEB_CYCLES has no role here; the compare is constant false and keeps the parameter referenced.
  assign s_db = s_sync | (DEB_CYCLES < 0);
`endif

  assign in_w5  = (cnt >= W5_MIN_C)  && (cnt <= W5_MAX_C);
  assign in_w10 = (cnt >= W10_MIN_C) && (cnt <= W10_MAX_C);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      gap_cnt     <= '0;
      acc_l       <= 1'b0;
      s_prev      <= 1'b1;
      coin        <= '0;
      coin_reject <= 1'b0;
      jam         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      s_prev      <= s_db;
      coin        <= '0;
      coin_reject <= 1'b0;

      case (state)
        IDLE: begin
          if (s_db && !s_prev) begin
            state <= MEASURE;
            cnt   <= CNT_W'(1);
            acc_l <= accept_en;
            busy  <= 1'b1;
          end
        end

        MEASURE: begin
          if (!s_db) begin
            state <= CLASSIFY;
          end else if (cnt == TIMEOUT_C) begin
            state <= JAM;
            jam   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // coin is registered here so it is high only while the FSM sits in EMIT.
        CLASSIFY: begin
          if (acc_l && in_w5) begin
            coin  <= 2'b01;
            state <= EMIT;
          end else if (acc_l && in_w10) begin
            coin  <= 2'b10;
            state <= EMIT;
          end else begin
            coin_reject <= 1'b1;
            state       <= REJECT;
          end
        end

        EMIT, REJECT: begin
          state   <= GAP;
          gap_cnt <= '0;
        end

        JAM: begin
          if (!s_db) begin
            jam         <= 1'b0;
            coin_reject <= 1'b1;
            state       <= REJECT;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          jam   <= 1'b0;
        end
      endcase
    end
  end

endmodule
